mainmem_pipe: RTL and testbench

- Word-organised main memory model with a fixed-latency, fully pipelined read path.
- Sits directly downstream of the cache arbiter and consumes its mainmem_addr, mainmem_write_data and mainmem_wr outputs.
- Returns fill words and a per-word valid strobe that the arbiter routes to the icache or dcache fill FSM.
- Accepts one request per cycle, so an 8-word cache-line fill streams back-to-back.

---
 rtl/mainmem_pipe.sv | 83 ++++++++
 tb/tb_mainmem_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mainmem_pipe.sv
// Word-organised main memory with a fixed-latency, fully pipelined read path.
// Writes land in the array on the request edge. Reads sample the array on the issue
// edge and travel down a LATENCY-deep shift pipeline together with their byte address
// and a valid bit. Bubbles carry zero data, so the outputs read 0 whenever data_valid=0.
module mainmem_pipe #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] rd_addr_out,
    output logic [2:0]  outstanding
);

    logic [15:0]   mem [2**AW];
    logic [AW-1:0] word_idx;
    logic          rd_issue;
    logic          wr_issue;
    logic [15:0]   rd_byte_addr;

    // Pipeline stage registers; index LATENCY-1 is the presented stage.
    logic [LATENCY-1:0] vld_q;
    logic [15:0]        dat_q [LATENCY];
    logic [15:0]        adr_q [LATENCY];
    logic [2:0]         outstanding_q;

    assign word_idx     = addr[AW:1];
    assign rd_issue     = enable & ~wr;
    assign wr_issue     = enable & wr;
    assign rd_byte_addr = addr & 16'hFFFE;

    // Array write port; a request coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_issue) begin
            mem[word_idx] <= data_in;
        end
    end

    // Read pipeline: stage 0 snapshots the array, later stages simply shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
                adr_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_issue;
            dat_q[0] <= rd_issue ? mem[word_idx] : 16'h0000;
            adr_q[0] <= rd_issue ? rd_byte_addr : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    // Reads in flight: +1 on issue, -1 once a presented read leaves the output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            case ({rd_issue, vld_q[LATENCY-1]})
                2'b10:   outstanding_q <= outstanding_q + 3'd1;
                2'b01:   outstanding_q <= outstanding_q - 3'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign data_valid  = vld_q[LATENCY-1];
    assign data_out    = dat_q[LATENCY-1];
    assign rd_addr_out = adr_q[LATENCY-1];
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_mainmem_pipe.sv
// Directed bench for mainmem_pipe with LATENCY=4, AW=15.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_mainmem_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [15:0] rd_addr_out;
    logic [2:0]  outstanding;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mainmem_pipe #(
        .LATENCY(4),
        .AW     (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .rd_addr_out(rd_addr_out),
        .outstanding(outstanding)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 16'h0100, 16'h5555);
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b want 0", data_valid);
        end
        checks++;
        if (outstanding !== 3'd0) begin
            errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
        end
        checks++;
        if (data_out !== 16'h0000) begin
            errors++; $display("FAIL reset_data: got %h want 0000", data_out);
        end
        checks++;
        if (rd_addr_out !== 16'h0000) begin
            errors++; $display("FAIL reset_addr: got %h want 0000", rd_addr_out);
        end
        // A write presented during reset must not reach the array.
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 16'h0100, 16'h1234);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 16'h0100, 16'hDEAD);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h0100, 16'h0000);
        tick();
        idle();
        tick();
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
            errors++;
            $display("FAIL reset_ignores_write: got v=%0b d=%h want v=1 d=1234",
                     data_valid, data_out);
        end
    endtask

    task automatic test_write_read();
        logic [2:0] exp_os [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        tick();
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        tick();
        idle();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (outstanding !== exp_os[k]) begin
                errors++;
                $display("FAIL wr_rd_outstanding[%0d]: got %0d want %0d", k, outstanding,
                         exp_os[k]);
            end
            checks++;
            if (data_valid !== (k == 3)) begin
                errors++;
                $display("FAIL wr_rd_valid[%0d]: got %0b want %0b", k, data_valid, k == 3);
            end
            if (k == 3) begin
                checks++;
                if (data_out !== 16'hBEEF || rd_addr_out !== 16'h0010) begin
                    errors++;
                    $display("FAIL wr_rd_data: got d=%h a=%h want d=beef a=0010",
                             data_out, rd_addr_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_burst();
        int         exp_os [13] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0};
        int         peak = 0;
        logic       exp_v;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 16'h0200 + 16'(2 * i);
            drive(1'b1, 1'b1, a, 16'h1000 + 16'(i));
            tick();
        end
        drive(1'b1, 1'b0, 16'h0200, 16'h0000);
        for (int c = 0; c < 13; c++) begin
            tick();
            if (c + 1 < 8) begin
                a = 16'h0200 + 16'(2 * (c + 1));
                drive(1'b1, 1'b0, a, 16'h0000);
            end else begin
                idle();
            end
            if (int'(outstanding) > peak) peak = int'(outstanding);
            checks++;
            if (int'(outstanding) !== exp_os[c]) begin
                errors++;
                $display("FAIL burst_outstanding[%0d]: got %0d want %0d", c, outstanding,
                         exp_os[c]);
            end
            exp_v = (c >= 3 && c <= 10);
            checks++;
            if (data_valid !== exp_v) begin
                errors++;
                $display("FAIL burst_valid[%0d]: got %0b want %0b", c, data_valid, exp_v);
            end
            checks++;
            if (exp_v) begin
                if (data_out !== 16'h1000 + 16'(c - 3) ||
                    rd_addr_out !== 16'h0200 + 16'(2 * (c - 3))) begin
                    errors++;
                    $display("FAIL burst_data[%0d]: got d=%h a=%h want d=%h a=%h", c,
                             data_out, rd_addr_out, 16'h1000 + 16'(c - 3),
                             16'h0200 + 16'(2 * (c - 3)));
                end
            end else if (data_out !== 16'h0000 || rd_addr_out !== 16'h0000) begin
                errors++;
                $display("FAIL burst_idle_out[%0d]: got d=%h a=%h want 0", c, data_out,
                         rd_addr_out);
            end
        end
        checks++;
        if (peak !== 4 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL burst_peak: got peak=%0d final=%0d want 4 and 0", peak,
                     outstanding);
        end
    endtask

    task automatic test_bubbles();
        logic        pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] exp_d;
        logic [15:0] exp_a;
        logic        exp_v;
        for (int t = 0; t < 9; t++) begin
            if (t < 4 && pat[t]) begin
                drive(1'b1, 1'b0, (t == 0) ? 16'h0200 : (t == 2) ? 16'h0202 : 16'h0204,
                      16'h0000);
            end else begin
                drive(1'b0, 1'b1, 16'h0200, 16'hFFFF);
            end
            tick();
            exp_v = (t + 1 == 4) || (t + 1 == 6) || (t + 1 == 7);
            exp_d = (t + 1 == 4) ? 16'h1000 : (t + 1 == 6) ? 16'h1001 :
                    (t + 1 == 7) ? 16'h1002 : 16'h0000;
            exp_a = (t + 1 == 4) ? 16'h0200 : (t + 1 == 6) ? 16'h0202 :
                    (t + 1 == 7) ? 16'h0204 : 16'h0000;
            checks++;
            if (data_valid !== exp_v || data_out !== exp_d || rd_addr_out !== exp_a) begin
                errors++;
                $display("FAIL bubbles[cycle %0d]: got v=%0b d=%h a=%h want v=%0b d=%h a=%h",
                         t + 1, data_valid, data_out, rd_addr_out, exp_v, exp_d, exp_a);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_snapshot();
        drive(1'b1, 1'b1, 16'h0040, 16'h1111);
        tick();
        drive(1'b1, 1'b0, 16'h0040, 16'h0000);
        tick();
        drive(1'b1, 1'b1, 16'h0040, 16'h2222);
        tick();
        drive(1'b1, 1'b0, 16'h0040, 16'h0000);
        tick();
        idle();
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h1111) begin
            errors++;
            $display("FAIL snapshot_old: got v=%0b d=%h want v=1 d=1111", data_valid, data_out);
        end
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++; $display("FAIL snapshot_gap: got v=%0b want 0", data_valid);
        end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h2222) begin
            errors++;
            $display("FAIL snapshot_new: got v=%0b d=%h want v=1 d=2222", data_valid, data_out);
        end
        tick();
    endtask

    task automatic test_enable_low();
        // wr=1 with enable=0 must leave the array alone.
        drive(1'b0, 1'b1, 16'h0040, 16'hFFFF);
        tick();
        drive(1'b1, 1'b0, 16'h0040, 16'h0000);
        tick();
        idle();
        tick();
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h2222) begin
            errors++;
            $display("FAIL enable_low_write: got v=%0b d=%h want v=1 d=2222",
                     data_valid, data_out);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 1'b1, 16'h0300, 16'h3333);
        tick();
        drive(1'b1, 1'b0, 16'h0300, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 16'h0302, 16'h0000);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0304, 16'h0000);
        tick();
        rst_n = 1'b1;
        idle();
        checks++;
        if (outstanding !== 3'd0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset_state: got os=%0d v=%0b want 0 and 0",
                     outstanding, data_valid);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (data_valid !== 1'b0 || outstanding !== 3'd0) begin
                errors++;
                $display("FAIL midflight_squash[%0d]: got v=%0b os=%0d want 0 and 0", k,
                         data_valid, outstanding);
            end
        end
        drive(1'b1, 1'b0, 16'h0300, 16'h0000);
        tick();
        idle();
        tick();
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h3333) begin
            errors++;
            $display("FAIL midflight_retained: got v=%0b d=%h want v=1 d=3333",
                     data_valid, data_out);
        end
        tick();
    endtask

    task automatic test_odd_addr();
        drive(1'b1, 1'b1, 16'h0031, 16'hA5A5);
        tick();
        drive(1'b1, 1'b0, 16'h0030, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 16'h0031, 16'h0000);
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'hA5A5 || rd_addr_out !== 16'h0030) begin
            errors++;
            $display("FAIL odd_addr_even_read: got v=%0b d=%h a=%h want v=1 d=a5a5 a=0030",
                     data_valid, data_out, rd_addr_out);
        end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'hA5A5 || rd_addr_out !== 16'h0030) begin
            errors++;
            $display("FAIL odd_addr_odd_read: got v=%0b d=%h a=%h want v=1 d=a5a5 a=0030",
                     data_valid, data_out, rd_addr_out);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_burst();
        test_bubbles();
        test_snapshot();
        test_enable_low();
        test_reset_midflight();
        test_odd_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
